// File: rtl/rtc_pkg.sv
// Field layout of the time/calendar/alarm-config buses, alarm mode encodings
// and Gregorian calendar helpers shared by the RTC core and its alarm channels.
package rtc_pkg;

    localparam int TIME_W   = 24;
    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 8;
    localparam int HOUR_LSB = 16;

    localparam int CAL_W    = 36;
    localparam int YEAR_LSB = 0;
    localparam int MON_LSB  = 16;
    localparam int WDAY_LSB = 24;
    localparam int DAY_LSB  = 28;

    localparam int CFG_W        = 31;
    localparam int CFG_WDAY_LSB = 0;
    localparam int CFG_DAY_LSB  = 4;
    localparam int CFG_MIN_LSB  = 12;
    localparam int CFG_HOUR_LSB = 20;
    localparam int CFG_MODE_LSB = 28;
    localparam int CFG_EN_BIT   = 30;

    typedef enum logic [1:0] {
        MODE_DAILY  = 2'd0,
        MODE_WEEKLY = 2'd1,
        MODE_DATE   = 2'd2,
        MODE_HOURLY = 2'd3
    } alarm_mode_e;

    function automatic logic is_leap(input logic [15:0] year);
        logic div4, div100, div400;
        div4   = (year[1:0] == 2'b00);
        div100 = ((year % 16'd100) == 16'd0);
        div400 = ((year % 16'd400) == 16'd0);
        return (div4 && !div100) || div400;
    endfunction

    // Out-of-range months report 31; callers validate the month separately.
    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [15:0] year);
        logic [7:0] d;
        case (month)
            8'd2:                    d = is_leap(year) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
            default:                 d = 8'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rtc_alarm_chan.sv
// One alarm channel: config register, match against the next-state time/calendar,
// and a sticky pending flag where a new match beats a simultaneous clear.
module rtc_alarm_chan
    import rtc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [CFG_W-1:0] cfg_i,
    input  logic             clr_i,
    input  logic             eval_i,
    input  logic [7:0]       hour_i,
    input  logic [7:0]       min_i,
    input  logic [7:0]       day_i,
    input  logic [3:0]       wday_i,
    output logic             pending_o,
    output logic             en_o
);

    logic [CFG_W-1:0] cfg_q;
    logic             pending_q;
    logic             pending_d;
    logic             hm_match;
    logic             hit;
    alarm_mode_e      mode;

    always_comb begin
        mode     = alarm_mode_e'(cfg_q[CFG_MODE_LSB +: 2]);
        hm_match = (hour_i == cfg_q[CFG_HOUR_LSB +: 8]) && (min_i == cfg_q[CFG_MIN_LSB +: 8]);
        case (mode)
            MODE_DAILY:  hit = hm_match;
            MODE_WEEKLY: hit = hm_match && (wday_i == cfg_q[CFG_WDAY_LSB +: 4]);
            MODE_DATE:   hit = hm_match && (day_i == cfg_q[CFG_DAY_LSB +: 8]);
            MODE_HOURLY: hit = (min_i == cfg_q[CFG_MIN_LSB +: 8]);
            default:     hit = 1'b0;
        endcase
        hit = hit && eval_i && cfg_q[CFG_EN_BIT];

        pending_d = pending_q;
        if (hit) begin
            pending_d = 1'b1;
        end else if (clr_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            if (wr_i) begin
                cfg_q <= cfg_i;
            end
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign en_o      = cfg_q[CFG_EN_BIT];

endmodule

// File: rtl/rtc_multi_alarm.sv
// RTC core: 1 Hz prescaler, time-of-day, leap-aware calendar and NUM_ALARMS alarm
// channels. Host loads are range-checked; rejected loads pulse set_err one cycle later.
module rtc_multi_alarm
    import rtc_pkg::*;
#(
    parameter int CLK_DIV    = 50000000,
    parameter int NUM_ALARMS = 4,
    parameter int RESET_YEAR = 2000,
    parameter int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_time,
    input  logic [TIME_W-1:0]     set_full_time,
    input  logic                  set_cal,
    input  logic [CAL_W-1:0]      set_full_cal,
    input  logic                  alarm_wr,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [CFG_W-1:0]      alarm_cfg,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic [TIME_W-1:0]     full_time,
    output logic [CAL_W-1:0]      full_cal,
    output logic                  tick,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm_irq,
    output logic                  set_err
);

    localparam int            PW      = $clog2(CLK_DIV);
    localparam logic [PW-1:0] CNT_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0]    day_q, day_d, mon_q, mon_d;
    logic [3:0]    wday_q, wday_d;
    logic [15:0]   year_q, year_d;
    logic          set_err_q, set_err_d;

    logic [7:0]  st_hour, st_min, st_sec, sc_day, sc_mon;
    logic [3:0]  sc_wday;
    logic [15:0] sc_year;
    logic        time_ok, cal_ok, tick_w, day_roll, eval_w;

    assign st_hour = set_full_time[HOUR_LSB +: 8];
    assign st_min  = set_full_time[MIN_LSB +: 8];
    assign st_sec  = set_full_time[SEC_LSB +: 8];
    assign sc_day  = set_full_cal[DAY_LSB +: 8];
    assign sc_wday = set_full_cal[WDAY_LSB +: 4];
    assign sc_mon  = set_full_cal[MON_LSB +: 8];
    assign sc_year = set_full_cal[YEAR_LSB +: 16];

    assign time_ok = set_time && (st_hour < 8'd24) && (st_min < 8'd60) && (st_sec < 8'd60);
    assign cal_ok  = set_cal && (sc_mon >= 8'd1) && (sc_mon <= 8'd12)
                  && (sc_wday >= 4'd1) && (sc_wday <= 4'd7)
                  && (sc_day >= 8'd1) && (sc_day <= days_in_month(sc_mon, sc_year));
    // An accepted time load restarts the second, so it swallows a coincident tick.
    assign tick_w  = !rst && (cnt_q == CNT_MAX) && !time_ok;

    always_comb begin
        cnt_d     = (time_ok || tick_w) ? '0 : cnt_q + PW'(1);
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        day_d     = day_q;
        wday_d    = wday_q;
        mon_d     = mon_q;
        year_d    = year_q;
        day_roll  = 1'b0;
        set_err_d = (set_time && !time_ok) || (set_cal && !cal_ok);

        if (tick_w) begin
            if (sec_q >= 8'd59) begin
                sec_d = 8'd0;
                if (min_q >= 8'd59) begin
                    min_d = 8'd0;
                    if (hour_q >= 8'd23) begin
                        hour_d   = 8'd0;
                        day_roll = 1'b1;
                    end else begin
                        hour_d = hour_q + 8'd1;
                    end
                end else begin
                    min_d = min_q + 8'd1;
                end
            end else begin
                sec_d = sec_q + 8'd1;
            end
        end

        if (day_roll) begin
            wday_d = (wday_q >= 4'd7) ? 4'd1 : wday_q + 4'd1;
            if (day_q >= days_in_month(mon_q, year_q)) begin
                day_d = 8'd1;
                if (mon_q >= 8'd12) begin
                    mon_d  = 8'd1;
                    year_d = year_q + 16'd1;
                end else begin
                    mon_d = mon_q + 8'd1;
                end
            end else begin
                day_d = day_q + 8'd1;
            end
        end

        if (time_ok) begin
            hour_d = st_hour;
            min_d  = st_min;
            sec_d  = st_sec;
        end
        if (cal_ok) begin
            day_d  = sc_day;
            wday_d = sc_wday;
            mon_d  = sc_mon;
            year_d = sc_year;
        end

        eval_w = tick_w && (sec_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sec_q     <= 8'd0;
            min_q     <= 8'd0;
            hour_q    <= 8'd0;
            day_q     <= 8'd1;
            wday_q    <= 4'd1;
            mon_q     <= 8'd1;
            year_q    <= 16'(RESET_YEAR);
            set_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            day_q     <= day_d;
            wday_q    <= wday_d;
            mon_q     <= mon_d;
            year_q    <= year_d;
            set_err_q <= set_err_d;
        end
    end

    logic [NUM_ALARMS-1:0] en_w;

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
        rtc_alarm_chan u_chan (
            .clk       (clk),
            .rst       (rst),
            .wr_i      (alarm_wr && (alarm_sel == AW'(i))),
            .cfg_i     (alarm_cfg),
            .clr_i     (alarm_clr[i]),
            .eval_i    (eval_w),
            .hour_i    (hour_d),
            .min_i     (min_d),
            .day_i     (day_d),
            .wday_i    (wday_d),
            .pending_o (alarm_pending[i]),
            .en_o      (en_w[i])
        );
    end

    assign full_time = {hour_q, min_q, sec_q};
    assign full_cal  = {day_q, wday_q, mon_q, year_q};
    assign tick      = tick_w;
    assign alarm_irq = |(alarm_pending & en_w);
    assign set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Bench for rtc_multi_alarm: directed calendar/alarm scenarios followed by random
// host traffic, all checked every cycle against a seconds-of-day reference model.
module tb_rtc_multi_alarm;

    localparam int CLK_DIV = 4;
    localparam int NA      = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_time;
    logic [23:0]   set_full_time;
    logic          set_cal;
    logic [35:0]   set_full_cal;
    logic          alarm_wr;
    logic [1:0]    alarm_sel;
    logic [30:0]   alarm_cfg;
    logic [NA-1:0] alarm_clr;
    logic [23:0]   full_time;
    logic [35:0]   full_cal;
    logic          tick;
    logic [NA-1:0] alarm_pending;
    logic          alarm_irq;
    logic          set_err;

    always #5 clk = ~clk;

    rtc_multi_alarm #(.CLK_DIV(CLK_DIV), .NUM_ALARMS(NA), .RESET_YEAR(2000)) dut (
        .clk(clk), .rst(rst),
        .set_time(set_time), .set_full_time(set_full_time),
        .set_cal(set_cal), .set_full_cal(set_full_cal),
        .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_cfg(alarm_cfg),
        .alarm_clr(alarm_clr),
        .full_time(full_time), .full_cal(full_cal), .tick(tick),
        .alarm_pending(alarm_pending), .alarm_irq(alarm_irq), .set_err(set_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: time kept as seconds since midnight.
    int m_cnt, m_tod, m_day, m_wd, m_mon, m_year;
    bit m_err;
    int a_en[NA], a_mode[NA], a_hr[NA], a_mn[NA], a_dy[NA], a_wd[NA];
    bit m_pend[NA];

    function automatic int dim(input int mon, input int yr);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        bit leap;
        if (mon < 1 || mon > 12) return 31;
        leap = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
        return (mon == 2 && leap) ? 29 : tbl[mon-1];
    endfunction

    function automatic bit time_valid(input logic [23:0] t);
        return (int'(t[23:16]) < 24) && (int'(t[15:8]) < 60) && (int'(t[7:0]) < 60);
    endfunction

    function automatic bit cal_valid(input logic [35:0] c);
        int d, w, mo, y;
        d = int'(c[35:28]); w = int'(c[27:24]); mo = int'(c[23:16]); y = int'(c[15:0]);
        return (mo >= 1) && (mo <= 12) && (w >= 1) && (w <= 7) && (d >= 1) && (d <= dim(mo, y));
    endfunction

    function automatic logic [23:0] exp_time();
        return {8'(m_tod / 3600), 8'((m_tod / 60) % 60), 8'(m_tod % 60)};
    endfunction

    function automatic logic [35:0] exp_cal();
        return {8'(m_day), 4'(m_wd), 8'(m_mon), 16'(m_year)};
    endfunction

    function automatic logic [NA-1:0] exp_pend();
        logic [NA-1:0] p;
        for (int i = 0; i < NA; i++) p[i] = m_pend[i];
        return p;
    endfunction

    function automatic logic exp_irq();
        logic r = 1'b0;
        for (int i = 0; i < NA; i++) if (m_pend[i] && a_en[i] != 0) r = 1'b1;
        return r;
    endfunction

    function automatic bit alarm_match(input int i);
        int hr, mn;
        hr = m_tod / 3600;
        mn = (m_tod / 60) % 60;
        case (a_mode[i])
            0:       return hr == a_hr[i] && mn == a_mn[i];
            1:       return hr == a_hr[i] && mn == a_mn[i] && m_wd == a_wd[i];
            2:       return hr == a_hr[i] && mn == a_mn[i] && m_day == a_dy[i];
            default: return mn == a_mn[i];
        endcase
    endfunction

    function automatic logic exp_tick();
        return !rst && (m_cnt == CLK_DIV - 1) && !(set_time && time_valid(set_full_time));
    endfunction

    task automatic next_day();
        m_wd = (m_wd % 7) + 1;
        if (m_day >= dim(m_mon, m_year)) begin
            m_day = 1;
            if (m_mon == 12) begin
                m_mon  = 1;
                m_year = (m_year + 1) % 65536;
            end else begin
                m_mon++;
            end
        end else begin
            m_day++;
        end
    endtask

    task automatic model_edge();
        bit tv, cv, tk, fire;
        if (rst) begin
            m_cnt = 0; m_tod = 0; m_day = 1; m_wd = 1; m_mon = 1; m_year = 2000; m_err = 0;
            for (int i = 0; i < NA; i++) begin
                a_en[i] = 0; a_mode[i] = 0; a_hr[i] = 0; a_mn[i] = 0; a_dy[i] = 0; a_wd[i] = 0;
                m_pend[i] = 0;
            end
            return;
        end
        tv    = set_time && time_valid(set_full_time);
        cv    = set_cal && cal_valid(set_full_cal);
        tk    = (m_cnt == CLK_DIV - 1) && !tv;
        fire  = 0;
        m_err = (set_time && !tv) || (set_cal && !cv);
        if (tv) begin
            m_cnt = 0;
            m_tod = int'(set_full_time[23:16]) * 3600 + int'(set_full_time[15:8]) * 60
                  + int'(set_full_time[7:0]);
        end else begin
            m_cnt = (m_cnt + 1) % CLK_DIV;
            if (tk) begin
                m_tod++;
                if (m_tod == 86400) begin
                    m_tod = 0;
                    next_day();
                end
                fire = (m_tod % 60 == 0);
            end
        end
        if (cv) begin
            m_day  = int'(set_full_cal[35:28]);
            m_wd   = int'(set_full_cal[27:24]);
            m_mon  = int'(set_full_cal[23:16]);
            m_year = int'(set_full_cal[15:0]);
        end
        for (int i = 0; i < NA; i++) begin
            if (fire && a_en[i] != 0 && alarm_match(i)) m_pend[i] = 1;
            else if (alarm_clr[i]) m_pend[i] = 0;
        end
        if (alarm_wr && int'(alarm_sel) < NA) begin
            a_en[alarm_sel]   = int'(alarm_cfg[30]);
            a_mode[alarm_sel] = int'(alarm_cfg[29:28]);
            a_hr[alarm_sel]   = int'(alarm_cfg[27:20]);
            a_mn[alarm_sel]   = int'(alarm_cfg[19:12]);
            a_dy[alarm_sel]   = int'(alarm_cfg[11:4]);
            a_wd[alarm_sel]   = int'(alarm_cfg[3:0]);
        end
    endtask

    task automatic cycle();
        #1;
        chk("tick", tick, exp_tick());
        @(posedge clk);
        model_edge();
        #1;
        chk("full_time", full_time, exp_time());
        chk("full_cal", full_cal, exp_cal());
        chk("pending", alarm_pending, exp_pend());
        chk("irq", alarm_irq, exp_irq());
        chk("set_err", set_err, m_err);
        set_time  = 1'b0;
        set_cal   = 1'b0;
        alarm_wr  = 1'b0;
        alarm_clr = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic put_time(input int h, input int m, input int s);
        set_time      = 1'b1;
        set_full_time = {8'(h), 8'(m), 8'(s)};
    endtask

    task automatic put_cal(input int d, input int w, input int mo, input int y);
        set_cal      = 1'b1;
        set_full_cal = {8'(d), 4'(w), 8'(mo), 16'(y)};
    endtask

    task automatic put_alarm(input int sel, input int en, input int mode, input int hr,
                             input int mn, input int dy, input int wd);
        alarm_wr  = 1'b1;
        alarm_sel = 2'(sel);
        alarm_cfg = {1'(en), 2'(mode), 8'(hr), 8'(mn), 8'(dy), 4'(wd)};
    endtask

    initial begin
        rst = 1'b1; set_time = 1'b0; set_full_time = '0; set_cal = 1'b0; set_full_cal = '0;
        alarm_wr = 1'b0; alarm_sel = '0; alarm_cfg = '0; alarm_clr = '0;
        run(2);
        chk("rst_time", full_time, 24'h000000);
        chk("rst_cal", full_cal, {8'd1, 4'd1, 8'd1, 16'd2000});
        rst = 1'b0;

        run(240);
        chk("one_minute", full_time, {8'd0, 8'd1, 8'd0});
        chk("one_minute_cal", full_cal, {8'd1, 4'd1, 8'd1, 16'd2000});

        put_time(23, 59, 59); put_cal(28, 1, 2, 2000); cycle(); run(CLK_DIV);
        chk("leap_29feb_time", full_time, 24'h000000);
        chk("leap_29feb", full_cal, {8'd29, 4'd2, 8'd2, 16'd2000});
        put_time(23, 59, 59); cycle(); run(CLK_DIV);
        chk("leap_1mar", full_cal, {8'd1, 4'd3, 8'd3, 16'd2000});
        put_time(23, 59, 59); put_cal(28, 1, 2, 1900); cycle(); run(CLK_DIV);
        chk("noleap_1mar", full_cal, {8'd1, 4'd2, 8'd3, 16'd1900});

        put_cal(31, 1, 4, 2000); cycle();
        chk("bad_cal_err", set_err, 1'b1);
        chk("bad_cal_keep", full_cal, {8'd1, 4'd2, 8'd3, 16'd1900});
        cycle();
        chk("err_one_cycle", set_err, 1'b0);
        put_time(24, 0, 0); cycle();
        chk("bad_time_err", set_err, 1'b1);
        chk("bad_time_keep", full_time, 24'h000000);

        put_alarm(2, 1, 0, 7, 30, 0, 0); cycle();
        put_time(7, 29, 59); cycle(); run(CLK_DIV);
        chk("daily_time", full_time, {8'd7, 8'd30, 8'd0});
        chk("daily_pend", alarm_pending, 4'b0100);
        chk("daily_irq", alarm_irq, 1'b1);
        alarm_clr = 4'b0100; cycle();
        chk("daily_clr", alarm_pending, 4'b0000);
        chk("daily_clr_irq", alarm_irq, 1'b0);

        put_alarm(0, 1, 1, 7, 30, 0, 3); put_cal(10, 2, 5, 2000); cycle();
        put_time(7, 29, 59); cycle(); run(CLK_DIV);
        chk("weekly_miss", alarm_pending[0], 1'b0);
        put_cal(11, 3, 5, 2000); put_time(7, 29, 59); cycle(); run(CLK_DIV);
        chk("weekly_hit", alarm_pending[0], 1'b1);
        alarm_clr = 4'b1111; cycle();
        put_time(7, 30, 0); cycle(); run(2 * CLK_DIV);
        chk("load_no_alarm", alarm_pending, 4'b0000);

        put_alarm(1, 1, 3, 0, 30, 0, 0); cycle();
        put_time(7, 29, 59); cycle(); run(CLK_DIV);
        chk("hourly_hit", alarm_pending[1], 1'b1);
        put_time(7, 29, 59); cycle(); run(CLK_DIV - 1);
        alarm_clr = 4'b0010; cycle();
        chk("set_beats_clr", alarm_pending[1], 1'b1);
        alarm_clr = 4'b0101; cycle();
        put_alarm(1, 0, 3, 0, 30, 0, 0); cycle();
        chk("disabled_irq", alarm_irq, 1'b0);
        chk("disabled_keeps", alarm_pending, 4'b0010);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rerst_time", full_time, 24'h000000);
        chk("rerst_cal", full_cal, {8'd1, 4'd1, 8'd1, 16'd2000});
        chk("rerst_pend", alarm_pending, 4'b0000);
        chk("rerst_irq", alarm_irq, 1'b0);

        for (int k = 0; k < 4000; k++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 6) begin
                int hs;
                hs = int'($urandom_range(0, 3));
                put_time(hs == 0 ? 7 : hs == 1 ? 23 : int'($urandom_range(0, 24)),
                         $urandom_range(0, 1) ? 29 : int'($urandom_range(58, 60)),
                         int'($urandom_range(50, 60)));
            end else if (r < 10) begin
                int ys;
                ys = int'($urandom_range(0, 4));
                put_cal(int'($urandom_range(0, 32)), int'($urandom_range(0, 8)),
                        int'($urandom_range(0, 13)),
                        ys == 0 ? 1900 : ys == 1 ? 2000 : ys == 2 ? 2024 : ys == 3 ? 2023 : 65535);
            end
            if (r >= 10 && r < 16) begin
                put_alarm(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)),
                          $urandom_range(0, 1) ? 7 : 0,
                          $urandom_range(0, 1) ? 30 : 0,
                          int'($urandom_range(1, 31)), int'($urandom_range(1, 7)));
            end
            if (r >= 16 && r < 24) alarm_clr = 4'($urandom_range(0, 15));
            if (r == 199) rst = 1'b1;
            cycle();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
